// File: rtl/pyfive_wb_guard_pkg.sv
// Shared definitions for the pyfive Wishbone bus-side blocks:
// FSM state encodings and the default read data returned on a timeout.
package pyfive_wb_guard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] TMO_DATA_DEFAULT = 32'hDEADBEEF;
  localparam int          TMO_CNT_W        = 16;

endpackage

// File: rtl/pyfive_wb_guard.sv
// Registered Wishbone bridge from the management-core slave port to the pyfive bus
// splitter; forces completion of any transfer a peripheral never acknowledges.
module pyfive_wb_guard
  import pyfive_wb_guard_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] TMO_DATA = TMO_DATA_DEFAULT,
  parameter int          CW       = $clog2(TIMEOUT + 1)
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_dat_i,
  input  logic [31:0]          wbs_adr_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_we_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_dat_o,
  output logic [31:0]          wbm_adr_o,
  input  logic                 wbm_ack_i,
  input  logic [31:0]          wbm_dat_i,
  input  logic                 tmo_clr,
  output logic                 tmo_evt,
  output logic [TMO_CNT_W-1:0] tmo_cnt
);

  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   rsp_dat;
  logic          accept;
  logic          abort;
  logic          done_ack;
  logic          done_tmo;

  assign accept   = (state == IDLE) && wbs_cyc_i && wbs_stb_i;
  assign abort    = (state == BUSY) && !wbs_cyc_i;
  assign done_ack = (state == BUSY) && wbs_cyc_i && wbm_ack_i;
  // An ack arriving on the last wait cycle wins over the timeout.
  assign done_tmo = (state == BUSY) && wbs_cyc_i && !wbm_ack_i && (wait_cnt == TMO_LAST);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY: begin
        if (abort)                      state_nxt = IDLE;
        else if (done_ack || done_tmo)  state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbs_ack_o = 1'b0;
    wbs_dat_o = 32'd0;
    case (state)
      BUSY: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
      end
      RESP: begin
        wbs_ack_o = 1'b1;
        wbs_dat_o = rsp_dat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbm_adr_o <= 32'd0;
      wbm_dat_o <= 32'd0;
      wbm_sel_o <= 4'd0;
      wbm_we_o  <= 1'b0;
      wait_cnt  <= '0;
      rsp_dat   <= 32'd0;
      tmo_evt   <= 1'b0;
    end else begin
      tmo_evt <= done_tmo;
      if (accept) begin
        wbm_adr_o <= wbs_adr_i;
        wbm_dat_o <= wbs_dat_i;
        wbm_sel_o <= wbs_sel_i;
        wbm_we_o  <= wbs_we_i;
        wait_cnt  <= '0;
      end else if (done_ack) begin
        rsp_dat <= wbm_we_o ? 32'd0 : wbm_dat_i;
      end else if (done_tmo) begin
        rsp_dat <= wbm_we_o ? 32'd0 : TMO_DATA;
      end else if ((state == BUSY) && !abort) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  // A clear coinciding with a timeout pulse keeps that one event.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                  tmo_cnt <= '0;
    else if (tmo_clr)              tmo_cnt <= {{(TMO_CNT_W-1){1'b0}}, tmo_evt};
    else if (tmo_evt && !(&tmo_cnt)) tmo_cnt <= tmo_cnt + TMO_CNT_W'(1);
  end

endmodule

// File: tb/tb_pyfive_wb_guard.sv
// Directed bench for pyfive_wb_guard with a configurable downstream slave
// and a scoreboard of expected upstream responses.
module tb_pyfive_wb_guard;

  localparam int TMO = 4;
  localparam int M_ACKCYC = 0, M_DELAY = 1, M_NOACK = 2, M_LATE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i, wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        wbm_stb_o, wbm_cyc_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_o, wbm_adr_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        tmo_clr;
  logic        tmo_evt;
  logic [15:0] tmo_cnt;

  int          slv_mode;
  int          slv_delay;
  int          slv_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] dat;
    int          lat;
    int          evt;
    int          busy;
  } exp_t;
  exp_t sb[$];

  pyfive_wb_guard #(.TIMEOUT(TMO)) dut (
    .wb_clk_i (clk),       .wb_rst_i (rst),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o), .wbm_adr_o(wbm_adr_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .tmo_clr  (tmo_clr),   .tmo_evt  (tmo_evt),   .tmo_cnt  (tmo_cnt)
  );

  always #5 clk = ~clk;

  // Downstream slave: cycle k of a transfer sees slv_cnt == k-1.
  always_ff @(posedge clk) begin
    if (wbm_cyc_o) slv_cnt <= slv_cnt + 1;
    else           slv_cnt <= 0;
  end

  always_comb begin
    wbm_ack_i = 1'b0;
    case (slv_mode)
      M_ACKCYC: wbm_ack_i = wbm_cyc_o & wbm_stb_o;
      M_DELAY:  wbm_ack_i = wbm_cyc_o & wbm_stb_o & (slv_cnt == slv_delay);
      M_LATE:   wbm_ack_i = ~wbm_cyc_o;
      default:  wbm_ack_i = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [31:0] exp_dat, input int exp_lat,
                      input int exp_evt, input int exp_busy, input logic clr);
    exp_t e;
    int   n, evts, busy;
    bit   done;
    logic [31:0] got;
    e.dat = exp_dat; e.lat = exp_lat; e.evt = exp_evt; e.busy = exp_busy;
    sb.push_back(e);
    wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    n = 0; evts = 0; busy = 0; done = 0; got = 32'd0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (wbm_cyc_o) busy++;
      if (tmo_evt) evts++;
      if (n == 1) begin
        check("wbm_adr", wbm_adr_o, adr);
        check("wbm_dat", wbm_dat_o, dat);
        check("wbm_sel", {28'd0, wbm_sel_o}, {28'd0, sel});
        check("wbm_we", {31'd0, wbm_we_o}, {31'd0, we});
      end
      if (wbs_ack_o) begin
        done = 1;
        got = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        tmo_clr = clr;
      end else begin
        check("dat_while_no_ack", wbs_dat_o, 32'd0);
      end
    end
    check("ack_seen", {31'd0, done}, 32'd1);
    e = sb.pop_front();
    check("rsp_data", got, e.dat);
    check("ack_latency", n, e.lat);
    check("evt_pulses", evts, e.evt);
    check("wbm_cyc_cycles", busy, e.busy);
    @(negedge clk);
    tmo_clr = 1'b0;
    check("ack_single_pulse", {31'd0, wbs_ack_o}, 32'd0);
    check("evt_single_pulse", {31'd0, tmo_evt}, 32'd0);
    check("wbm_cyc_after", {31'd0, wbm_cyc_o}, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    wbs_sel_i = 0; wbs_dat_i = 0; wbs_adr_i = 0;
    wbm_dat_i = 32'd0; tmo_clr = 0;
    slv_mode = M_ACKCYC; slv_delay = 0;
    repeat (2) @(negedge clk);
    check("rst_wbs_ack", {31'd0, wbs_ack_o}, 32'd0);
    check("rst_wbm_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    check("rst_tmo_cnt", {16'd0, tmo_cnt}, 32'd0);
    check("rst_wbm_adr", wbm_adr_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Ack-is-cyc read
    slv_mode = M_ACKCYC; wbm_dat_i = 32'h12345678;
    xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, 32'h12345678, 2, 0, 1, 1'b0);
    check("cnt_after_read", {16'd0, tmo_cnt}, 32'd0);

    // Write, slave acks in the third BUSY cycle
    slv_mode = M_DELAY; slv_delay = 2; wbm_dat_i = 32'h5555_AAAA;
    xfer(1'b1, 32'h3000_0010, 32'hA5A5A5A5, 4'b0011, 32'h0, 4, 0, 3, 1'b0);

    // Read timeout; slave acks only outside BUSY, i.e. during RESP
    slv_mode = M_LATE;
    xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, 32'hDEADBEEF, TMO + 1, 1, TMO, 1'b0);
    check("cnt_after_tmo", {16'd0, tmo_cnt}, 32'd1);
    check("state_idle_after_late_ack", {30'd0, dut.state}, 32'd0);

    // Ack on the final wait cycle is a normal completion
    slv_mode = M_DELAY; slv_delay = TMO - 1; wbm_dat_i = 32'hCAFEF00D;
    xfer(1'b0, 32'h3000_0030, 32'h0, 4'hF, 32'hCAFEF00D, TMO + 1, 0, TMO, 1'b0);
    check("cnt_after_last_ack", {16'd0, tmo_cnt}, 32'd1);

    // Write timeout returns zero data
    slv_mode = M_NOACK;
    xfer(1'b1, 32'h3000_0040, 32'h1111_2222, 4'hC, 32'h0, TMO + 1, 1, TMO, 1'b0);
    check("cnt_after_wr_tmo", {16'd0, tmo_cnt}, 32'd2);

    // Upstream abort in BUSY cycle 2
    slv_mode = M_NOACK;
    wbs_we_i = 0; wbs_adr_i = 32'h3000_0050; wbs_cyc_i = 1; wbs_stb_i = 1;
    @(negedge clk);
    check("abort_busy1", {31'd0, wbm_cyc_o}, 32'd1);
    @(negedge clk);
    check("abort_busy2", {31'd0, wbm_cyc_o}, 32'd1);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_wbm_cyc", {31'd0, wbm_cyc_o}, 32'd0);
      check("abort_no_ack", {31'd0, wbs_ack_o}, 32'd0);
      check("abort_no_evt", {31'd0, tmo_evt}, 32'd0);
    end
    check("abort_state", {30'd0, dut.state}, 32'd0);
    check("cnt_after_abort", {16'd0, tmo_cnt}, 32'd2);

    // Asynchronous reset in the middle of BUSY
    wbs_adr_i = 32'h3000_0060; wbs_cyc_i = 1; wbs_stb_i = 1;
    @(negedge clk);
    check("pre_rst_busy", {31'd0, wbm_cyc_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_wbm_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    check("arst_wbm_stb", {31'd0, wbm_stb_o}, 32'd0);
    check("arst_wbm_adr", wbm_adr_o, 32'd0);
    check("arst_wbs_ack", {31'd0, wbs_ack_o}, 32'd0);
    check("arst_tmo_cnt", {16'd0, tmo_cnt}, 32'd0);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    slv_mode = M_ACKCYC; wbm_dat_i = 32'h0BAD_F00D;
    xfer(1'b0, 32'h3000_0070, 32'h0, 4'hF, 32'h0BADF00D, 2, 0, 1, 1'b0);

    // Clear coinciding with a timeout pulse
    slv_mode = M_NOACK;
    xfer(1'b0, 32'h3000_0080, 32'h0, 4'hF, 32'hDEADBEEF, TMO + 1, 1, TMO, 1'b0);
    check("cnt_one", {16'd0, tmo_cnt}, 32'd1);
    xfer(1'b0, 32'h3000_0084, 32'h0, 4'hF, 32'hDEADBEEF, TMO + 1, 1, TMO, 1'b1);
    check("clr_with_evt", {16'd0, tmo_cnt}, 32'd1);
    tmo_clr = 1'b1;
    @(negedge clk);
    tmo_clr = 1'b0;
    check("clr_alone", {16'd0, tmo_cnt}, 32'd0);

    // Saturation: preload just below full scale, then two more timeouts
    force dut.tmo_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.tmo_cnt;
    @(negedge clk);
    check("preload", {16'd0, tmo_cnt}, 32'h0000FFFE);
    xfer(1'b0, 32'h3000_0090, 32'h0, 4'hF, 32'hDEADBEEF, TMO + 1, 1, TMO, 1'b0);
    check("reach_full", {16'd0, tmo_cnt}, 32'h0000FFFF);
    xfer(1'b0, 32'h3000_0094, 32'h0, 4'hF, 32'hDEADBEEF, TMO + 1, 1, TMO, 1'b0);
    check("saturate", {16'd0, tmo_cnt}, 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
